// File: rtl/ctrl_ramdrv_tapseq_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_ramdrv_tapseq_pkg
// Shared definitions for the polyphase tap sequencer: FSM state encoding and
// the default geometry constants used as parameter defaults by the top.
// ----------------------------------------------------------------------------
package ctrl_ramdrv_tapseq_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_TAP_WIDTH  = 8;
    localparam int DEF_PIPE_LAT   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } tapseq_state_t;

endpackage

// File: rtl/ctrl_ramdrv_delayline.sv
// ----------------------------------------------------------------------------
// ctrl_ramdrv_delayline
// Fixed-depth register delay line used to align MAC control strobes with the
// RAM/multiplier pipeline. DEPTH=0 degenerates to a wire.
// Ports:
//   clk    in   clock
//   clr_n  in   asynchronous active-low reset (clears every stage)
//   i_clr  in   synchronous clear of every stage
//   i_d    in   WIDTH-bit data in
//   o_q    out  i_d delayed DEPTH cycles
// ----------------------------------------------------------------------------
module ctrl_ramdrv_delayline #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            // Shift register stages with async reset and sync flush
            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n) begin
                    for (int i = 0; i < DEPTH; i++) r_pipe[i] <= {WIDTH{1'b0}};
                end else if (i_clr) begin
                    for (int i = 0; i < DEPTH; i++) r_pipe[i] <= {WIDTH{1'b0}};
                end else begin
                    r_pipe[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign o_q = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/ctrl_ramdrv_tapseq.sv
// ----------------------------------------------------------------------------
// ctrl_ramdrv_tapseq
// Sequencer for one polyphase FIR output: loads the coefficient counter,
// walks the sample RAM backwards from the newest sample for N taps, and
// drives MAC clear/enable aligned to the datapath latency PIPE_LAT.
// Optional feature macro: CTRL_TAPSEQ_ABORT_EN (adds input abort).
// Ports:
//   clk, clr_n           clock, async active-low reset
//   start                one-cycle request (honoured in IDLE only)
//   phase_ptr, data_ptr  coefficient base / newest sample address
//   tap_num              number of taps N
//   coef_load, coef_cnt  coefficient address counter load / count enable
//   data_addr            sample RAM read address
//   mac_clr, mac_en      accumulator clear / enable (delayed PIPE_LAT)
//   busy, done           not-idle flag / result valid pulse
//   abort (optional)     return to IDLE, flush pipeline, no done
// All outputs are registered.
// ----------------------------------------------------------------------------
module ctrl_ramdrv_tapseq
    import ctrl_ramdrv_tapseq_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TAP_WIDTH  = DEF_TAP_WIDTH,
    parameter int PIPE_LAT   = DEF_PIPE_LAT
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  start,
`ifdef CTRL_TAPSEQ_ABORT_EN
    input  logic                  abort,
`endif
    input  logic [ADDR_WIDTH-1:0] phase_ptr,
    input  logic [ADDR_WIDTH-1:0] data_ptr,
    input  logic [TAP_WIDTH-1:0]  tap_num,
    output logic                  coef_load,
    output logic                  coef_cnt,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic                  mac_clr,
    output logic                  mac_en,
    output logic                  busy,
    output logic                  done
);

    localparam int FLUSH_W = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT);

    tapseq_state_t         r_state;
    tapseq_state_t         w_next_state;
    logic                  w_abort;
    logic                  w_last_tap;
    logic                  w_last_flush;

    logic [ADDR_WIDTH-1:0] r_phase_ptr;
    logic [ADDR_WIDTH-1:0] r_data_ptr;
    logic [TAP_WIDTH-1:0]  r_tap_num;
    logic [TAP_WIDTH-1:0]  r_tap_cnt;
    logic [FLUSH_W-1:0]    r_flush_cnt;

    logic                  r_coef_load;
    logic                  r_coef_cnt;
    logic                  r_first_tap;
    logic [ADDR_WIDTH-1:0] r_data_addr;
    logic                  r_busy;
    logic                  r_done;
    logic [1:0]            w_dly_out;

    // Tap counter stops at N-1, so N = 2^TAP_WIDTH-1 never wraps it
    assign w_last_tap   = (r_tap_cnt == (r_tap_num - TAP_WIDTH'(1)));
    assign w_last_flush = (r_flush_cnt == FLUSH_W'(PIPE_LAT - 1));

    // FSM state register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state decode; abort overrides everything outside IDLE
    always_comb begin
        w_next_state = r_state;
        w_abort      = 1'b0;
`ifdef CTRL_TAPSEQ_ABORT_EN
        w_abort      = abort && (r_state != ST_IDLE);
`endif
        if (w_abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) w_next_state = ST_LOAD;
                    else       w_next_state = ST_IDLE;
                end
                ST_LOAD: begin
                    if (r_tap_num != {TAP_WIDTH{1'b0}}) w_next_state = ST_RUN;
                    else                                w_next_state = ST_DONE;
                end
                ST_RUN: begin
                    if (!w_last_tap)        w_next_state = ST_RUN;
                    else if (PIPE_LAT == 0) w_next_state = ST_DONE;
                    else                    w_next_state = ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (w_last_flush) w_next_state = ST_DONE;
                    else              w_next_state = ST_FLUSH;
                end
                ST_DONE:  w_next_state = ST_IDLE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // Request capture, counters and registered outputs derived from next state
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_phase_ptr <= {ADDR_WIDTH{1'b0}};
            r_data_ptr  <= {ADDR_WIDTH{1'b0}};
            r_tap_num   <= {TAP_WIDTH{1'b0}};
            r_tap_cnt   <= {TAP_WIDTH{1'b0}};
            r_flush_cnt <= {FLUSH_W{1'b0}};
            r_coef_load <= 1'b0;
            r_coef_cnt  <= 1'b0;
            r_first_tap <= 1'b0;
            r_data_addr <= {ADDR_WIDTH{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_phase_ptr <= phase_ptr;
                r_data_ptr  <= data_ptr;
                r_tap_num   <= tap_num;
            end

            if (r_state == ST_LOAD)
                r_tap_cnt <= {TAP_WIDTH{1'b0}};
            else if ((r_state == ST_RUN) && !w_last_tap)
                r_tap_cnt <= r_tap_cnt + TAP_WIDTH'(1);

            if ((r_state == ST_FLUSH) && (w_next_state == ST_FLUSH))
                r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
            else
                r_flush_cnt <= {FLUSH_W{1'b0}};

            // LOAD shows the incoming pointer, tap 0 the captured one, then step back
            if (w_next_state == ST_LOAD)
                r_data_addr <= data_ptr;
            else if ((w_next_state == ST_RUN) && (r_state == ST_LOAD))
                r_data_addr <= r_data_ptr;
            else if (w_next_state == ST_RUN)
                r_data_addr <= r_data_addr - ADDR_WIDTH'(1);
            else
                r_data_addr <= {ADDR_WIDTH{1'b0}};

            r_coef_load <= (w_next_state == ST_LOAD);
            r_coef_cnt  <= (w_next_state == ST_RUN);
            r_first_tap <= (w_next_state == ST_RUN) && (r_state == ST_LOAD);
            r_busy      <= (w_next_state != ST_IDLE);
            r_done      <= (w_next_state == ST_DONE);
        end
    end

    // RUN indicator and tap-0 indicator ride the datapath latency
    ctrl_ramdrv_delayline #(
        .DEPTH (PIPE_LAT),
        .WIDTH (2)
    ) u_delayline (
        .clk   (clk),
        .clr_n (clr_n),
        .i_clr (w_abort),
        .i_d   ({r_first_tap, r_coef_cnt}),
        .o_q   (w_dly_out)
    );

    assign coef_load = r_coef_load;
    assign coef_cnt  = r_coef_cnt;
    assign data_addr = r_data_addr;
    assign mac_clr   = w_dly_out[1];
    assign mac_en    = w_dly_out[0];
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/ctrl_ramdrv_tapseq.md
CTRL_RAMDRV_TAPSEQ -- requirements
Module: ctrl_ramdrv_tapseq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: width of coefficient and sample RAM addresses.
REQ-002 SHALL have parameter TAP_WIDTH, default 8: width of the tap-count input.
REQ-003 SHALL have parameter PIPE_LAT, default 2: cycles from the last tap issue to the last MAC product valid.
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port clr_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  single-cycle request to compute one polyphase output.
REQ-007 SHALL have port phase_ptr  in  ADDR_WIDTH  coefficient base address of the selected phase.
REQ-008 SHALL have port data_ptr  in  ADDR_WIDTH  sample RAM address of the newest sample.
REQ-009 SHALL have port tap_num  in  TAP_WIDTH  number of taps N for this output.
REQ-010 SHALL have port coef_load  out  1  load strobe to the coefficient address counter.
REQ-011 SHALL have port coef_cnt  out  1  count enable to the coefficient address counter.
REQ-012 SHALL have port data_addr  out  ADDR_WIDTH  sample RAM read address.
REQ-013 SHALL have port mac_clr  out  1  accumulator clear, aligned with the first tap.
REQ-014 SHALL have port mac_en  out  1  accumulate enable, one per tap.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port done  out  1  single-cycle pulse: accumulator result valid.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN, FLUSH, DONE.
REQ-018 In IDLE, start=1 SHALL register phase_ptr, data_ptr and tap_num, and enter LOAD next cycle. start outside IDLE SHALL be ignored.
REQ-019 LOAD SHALL last exactly one cycle with coef_load=1 and data_addr=registered data_ptr. It SHALL go to RUN if N>0, else to DONE.
REQ-020 RUN SHALL last exactly N cycles with coef_cnt=1. Tap index k runs 0..N-1, and data_addr SHALL equal data_ptr-k modulo 2^ADDR_WIDTH.
REQ-021 The sample address SHALL wrap around 0 to 2^ADDR_WIDTH-1 with no flag or stall.
REQ-022 mac_en SHALL be the RUN indicator delayed PIPE_LAT cycles. mac_clr SHALL be the k=0 indicator delayed PIPE_LAT cycles.
REQ-023 FLUSH SHALL last exactly PIPE_LAT cycles, then go to DONE.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE. start is accepted again on the following cycle.
REQ-025 Total latency from start to done SHALL be N+PIPE_LAT+2 cycles for N>0, and 2 cycles for N=0. For N=0, mac_en and mac_clr never assert.
REQ-026 The internal tap counter SHALL be TAP_WIDTH bits and SHALL never wrap. N=2^TAP_WIDTH-1 SHALL be supported.

Reset
REQ-027 clr_n=0 SHALL force state IDLE and set every output to 0, including data_addr, regardless of the current state. This includes mid-RUN and mid-FLUSH.
REQ-028 After reset deassertion, the first start SHALL be honoured on the first rising edge.

Configuration
REQ-029 Macro CTRL_TAPSEQ_ABORT_EN SHALL add input abort (1 bit).
REQ-030 With CTRL_TAPSEQ_ABORT_EN, abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge. The abort SHALL clear the delay pipeline and suppress done. abort SHALL have priority over start.
REQ-031 Without CTRL_TAPSEQ_ABORT_EN, the port SHALL be absent and every accepted start SHALL produce exactly one done.

Structure
REQ-032 The FSM state encoding type and the default ADDR_WIDTH, TAP_WIDTH and PIPE_LAT constants SHALL live in the shared controller package.
REQ-033 The PIPE_LAT alignment delay for mac_en and mac_clr SHALL be sub-module ctrl_ramdrv_delayline (parameterised depth and width). The FSM and the address arithmetic remain in the top.

Verification
REQ-034 The bench SHALL check: N=4, phase_ptr=0x010, data_ptr=0x005, PIPE_LAT=2 -> coef_load at cycle 1, coef_cnt at cycles 2-5, data_addr 0x005/0x004/0x003/0x002, mac_en at cycles 4-7, mac_clr at cycle 4, done at cycle 8.
REQ-035 The bench SHALL check: data_ptr=0x001, N=3 -> data_addr 0x001, 0x000, 0xFFF.
REQ-036 The bench SHALL check: N=0 -> done at cycle 2, no coef_cnt/mac_en/mac_clr pulse.
REQ-037 The bench SHALL check: start held high throughout a N=4 run -> a second run begins only after done. phase_ptr changes during the run have no effect.
REQ-038 The bench SHALL check: clr_n=0 at the 3rd RUN cycle -> all outputs 0 immediately (asynchronously). A new start after release gives the nominal timing.
REQ-039 With CTRL_TAPSEQ_ABORT_EN, the bench SHALL check: abort in FLUSH -> IDLE next cycle, no done, and mac_en deasserted.
